// File: rtl/scaled_divider_pkg.sv
// Shared definitions for the scaled divider: controller states, default width
// and the quotient saturation constants.
package scaled_divider_pkg;

    localparam int DEFAULT_N = 8;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_e;

    function automatic logic [63:0] sat_max_pos(input int n);
        return (64'd1 << (n - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min_neg(input int n);
        return 64'd1 << (n - 1);
    endfunction

    function automatic logic [63:0] sat_max_uns(input int n);
        return (64'd1 << n) - 64'd1;
    endfunction

    // Saturated quotient bit pattern; its value is also the largest legal
    // quotient magnitude for that sign, so it doubles as the overflow limit.
    function automatic logic [63:0] sat_code(input int n, input logic signed_mode,
                                             input logic negative);
        if (!signed_mode) begin
            return sat_max_uns(n);
        end else if (negative) begin
            return sat_min_neg(n);
        end else begin
            return sat_max_pos(n);
        end
    endfunction

endpackage

// File: rtl/scaled_divider_core.sv
// Unsigned 2N-by-N restoring divider, one quotient bit per step, MSB first.
// Quotient bits shift in behind the dividend bits as they are consumed.
module scaled_divider_core
    import scaled_divider_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           start,
    input  logic           step,
    input  logic [2*N-1:0] dividend_mag,
    input  logic [N-1:0]   divisor_mag,
    output logic           last,
    output logic [2*N-1:0] quot_mag,
    output logic [N-1:0]   rem_mag
);

    localparam int CNT_W = $clog2(2 * N);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(2 * N - 1);

    logic [CNT_W-1:0] cnt;
    logic [2*N-1:0]   shift_q;
    logic [N-1:0]     part_q;
    logic [N-1:0]     dsr_q;
    logic [N:0]       trial;
    logic [N-1:0]     diff;
    logic             fits;

    // Partial remainder stays below the divisor, so the difference fits N bits.
    always_comb begin
        trial = {part_q, shift_q[2*N-1]};
        fits  = trial >= {1'b0, dsr_q};
        diff  = trial[N-1:0] - dsr_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (start) begin
            shift_q <= dividend_mag;
            part_q  <= '0;
            dsr_q   <= divisor_mag;
        end else if (step) begin
            shift_q <= {shift_q[2*N-2:0], fits};
            part_q  <= fits ? diff : trial[N-1:0];
        end
    end

    assign last     = (cnt == LAST_CNT);
    assign quot_mag = shift_q;
    assign rem_mag  = part_q;

endmodule

// File: rtl/scaled_divider.sv
// Signed/unsigned 2N-by-N divider with saturation: sign handling and the
// request/result handshake around the unsigned iterative core.
module scaled_divider
    import scaled_divider_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           In_Valid,
    output logic           In_Ready,
    input  logic [2*N-1:0] Dividend,
    input  logic [N-1:0]   Divisor,
    input  logic           A_Signed,
    input  logic           B_Signed,
    output logic           Out_Valid,
    input  logic           Out_Ready,
    output logic [N-1:0]   Quotient,
    output logic [N:0]     Remainder,
    output logic           Overflow,
    output logic           DivByZero
);

    localparam int DW = 2 * N;

    div_state_e     state;
    logic           accept;
    logic           a_is_neg;
    logic           b_is_neg;
    logic [2*N-1:0] a_mag;
    logic [N-1:0]   b_mag;
    logic           a_neg_q;
    logic           q_neg_q;
    logic           sgn_mode_q;
    logic           dbz_q;
    logic [N:0]     dvd_low_q;
    logic           core_last;
    logic [2*N-1:0] quot_mag;
    logic [N-1:0]   rem_mag;
    logic [2*N-1:0] limit;
    logic [N-1:0]   q_out;
    logic [N:0]     r_out;
    logic           ovf_out;

    assign accept = In_Valid & In_Ready;

    always_comb begin
        a_is_neg = A_Signed & Dividend[2*N-1];
        b_is_neg = B_Signed & Divisor[N-1];
        a_mag    = a_is_neg ? -Dividend : Dividend;
        b_mag    = b_is_neg ? -Divisor : Divisor;
    end

    always_ff @(posedge Clk) begin
        if (accept) begin
            a_neg_q    <= a_is_neg;
            q_neg_q    <= a_is_neg ^ b_is_neg;
            sgn_mode_q <= A_Signed | B_Signed;
            dbz_q      <= (Divisor == '0);
            dvd_low_q  <= Dividend[N:0];
        end
    end

    scaled_divider_core #(
        .N(N)
    ) u_core (
        .Clk          (Clk),
        .Reset        (Reset),
        .start        (accept),
        .step         (state == CALC),
        .dividend_mag (a_mag),
        .divisor_mag  (b_mag),
        .last         (core_last),
        .quot_mag     (quot_mag),
        .rem_mag      (rem_mag)
    );

    // Result shaping: a zero divisor saturates by the dividend sign alone.
    always_comb begin
        limit   = DW'(sat_code(N, sgn_mode_q, q_neg_q));
        ovf_out = 1'b0;
        r_out   = a_neg_q ? -{1'b0, rem_mag} : {1'b0, rem_mag};
        q_out   = q_neg_q ? -quot_mag[N-1:0] : quot_mag[N-1:0];
        if (dbz_q) begin
            q_out = N'(sat_code(N, sgn_mode_q, a_neg_q));
            r_out = dvd_low_q;
        end else if (quot_mag > limit) begin
            ovf_out = 1'b1;
            q_out   = N'(sat_code(N, sgn_mode_q, q_neg_q));
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            In_Ready  <= 1'b1;
            Out_Valid <= 1'b0;
            Quotient  <= '0;
            Remainder <= '0;
            Overflow  <= 1'b0;
            DivByZero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= CALC;
                        In_Ready <= 1'b0;
                    end
                end
                CALC: begin
                    if (core_last) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    state     <= DONE;
                    Out_Valid <= 1'b1;
                    Quotient  <= q_out;
                    Remainder <= r_out;
                    Overflow  <= ovf_out;
                    DivByZero <= dbz_q;
                end
                DONE: begin
                    if (Out_Ready) begin
                        state     <= IDLE;
                        Out_Valid <= 1'b0;
                        In_Ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scaled_divider.sv
// Scoreboard bench for scaled_divider: stimulus pushes expected results,
// an independent monitor compares them when Out_Valid appears.
module tb_scaled_divider;

    localparam int N = 8;

    logic           Clk = 1'b0;
    logic           Reset = 1'b1;
    logic           In_Valid = 1'b0;
    logic           In_Ready;
    logic [2*N-1:0] Dividend = '0;
    logic [N-1:0]   Divisor = '0;
    logic           A_Signed = 1'b0;
    logic           B_Signed = 1'b0;
    logic           Out_Valid;
    logic           Out_Ready = 1'b1;
    logic [N-1:0]   Quotient;
    logic [N:0]     Remainder;
    logic           Overflow;
    logic           DivByZero;

    typedef struct {
        logic [N-1:0] q;
        logic [N:0]   r;
        logic         ov;
        logic         dbz;
        int           acc_edge;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   seen = 1'b0;

    scaled_divider #(.N(N)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .A_Signed  (A_Signed),
        .B_Signed  (B_Signed),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Overflow  (Overflow),
        .DivByZero (DivByZero)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: plain integer division on the operands' numeric values.
    function automatic exp_t model(input logic [2*N-1:0] dvd, input logic [N-1:0] dvs,
                                   input bit as, input bit bs);
        exp_t   e;
        longint a, b, q, r, qmin, qmax;
        bit     sm;
        a    = as ? longint'($signed(dvd)) : longint'(dvd);
        b    = bs ? longint'($signed(dvs)) : longint'(dvs);
        sm   = as | bs;
        qmin = sm ? -(longint'(1) << (N - 1)) : 0;
        qmax = sm ? (longint'(1) << (N - 1)) - 1 : (longint'(1) << N) - 1;
        e.ov  = 1'b0;
        e.dbz = (b == 0);
        if (b == 0) begin
            q = (a < 0) ? qmin : qmax;
            r = longint'(dvd);
        end else begin
            q = a / b;
            r = a % b;
            if (q > qmax) begin
                q    = qmax;
                e.ov = 1'b1;
            end else if (q < qmin) begin
                q    = qmin;
                e.ov = 1'b1;
            end
        end
        e.q        = q[N-1:0];
        e.r        = r[N:0];
        e.acc_edge = 0;
        return e;
    endfunction

    task automatic issue(input logic [2*N-1:0] dvd, input logic [N-1:0] dvs,
                         input bit as, input bit bs, input exp_t e_in);
        exp_t e;
        bit   got;
        e   = e_in;
        got = 1'b0;
        @(posedge Clk); #1;
        Dividend = dvd;
        Divisor  = dvs;
        A_Signed = as;
        B_Signed = bs;
        In_Valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (In_Ready) begin
                e.acc_edge = cyc + 1;
                sb.push_back(e);
                got = 1'b1;
                break;
            end
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL accept_timeout: In_Ready=%0b required=1", In_Ready);
        end
        @(posedge Clk); #1;
        In_Valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk);
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL done_timeout: pending=%0d required=0", sb.size());
        end
    endtask

    task automatic wait_valid();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (Out_Valid) begin
                ok = 1'b1;
                break;
            end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL valid_timeout: Out_Valid=%0b required=1", Out_Valid);
        end
    endtask

    task automatic run_dir(input logic [2*N-1:0] dvd, input logic [N-1:0] dvs,
                           input bit as, input bit bs, input logic [N-1:0] q,
                           input logic [N:0] r, input bit ov, input bit dbz);
        exp_t e;
        e.q        = q;
        e.r        = r;
        e.ov       = ov;
        e.dbz      = dbz;
        e.acc_edge = 0;
        issue(dvd, dvs, as, bs, e);
        wait_done();
    endtask

    // Monitor: first appearance of each result is checked, the handshake pops it.
    always @(negedge Clk) begin
        if (Reset) begin
            seen = 1'b0;
        end else if (!Out_Valid) begin
            seen = 1'b0;
        end else if (sb.size() == 0) begin
            if (!seen) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: Out_Valid=1 required=0");
                seen = 1'b1;
            end
        end else begin
            if (!seen) begin
                seen = 1'b1;
                chk("latency", cyc + 1 - sb[0].acc_edge, 18);
                chk("quotient", Quotient, sb[0].q);
                chk("remainder", Remainder, sb[0].r);
                chk("overflow", Overflow, sb[0].ov);
                chk("divbyzero", DivByZero, sb[0].dbz);
            end
            if (Out_Ready) begin
                void'(sb.pop_front());
                seen = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        bit   any_valid;
        logic [2*N-1:0] rd;
        logic [N-1:0]   rv;
        bit   ra, rb;

        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);
        chk("rst_in_ready", In_Ready, 1);
        chk("rst_out_valid", Out_Valid, 0);
        chk("rst_quotient", Quotient, 0);
        chk("rst_remainder", Remainder, 0);
        chk("rst_overflow", Overflow, 0);
        chk("rst_divbyzero", DivByZero, 0);

        run_dir(16'h3F01, 8'h7F, 0, 0, 8'h7F, 9'h000, 0, 0);
        run_dir(16'hC080, 8'h7F, 1, 1, 8'h80, 9'h000, 0, 0);
        run_dir(16'hFFF9, 8'h02, 1, 1, 8'hFD, 9'h1FF, 0, 0);
        run_dir(16'h7F00, 8'h01, 0, 0, 8'hFF, 9'h000, 1, 0);
        run_dir(16'h8000, 8'hFF, 1, 1, 8'h7F, 9'h000, 1, 0);
        run_dir(16'hFF80, 8'h00, 1, 1, 8'h80, 9'h180, 0, 1);
        run_dir(16'h1234, 8'h00, 0, 0, 8'hFF, 9'h034, 0, 1);
        run_dir(16'hFFFF, 8'hFF, 0, 1, 8'h80, 9'h000, 1, 0);
        run_dir(16'h0064, 8'hF9, 1, 1, 8'hF2, 9'h002, 0, 0);
        run_dir(16'hFF9C, 8'h07, 1, 0, 8'hF2, 9'h1FE, 0, 0);

        // Consumer stall in DONE
        @(posedge Clk); #1 Out_Ready = 1'b0;
        e = model(16'h0064, 8'hF9, 1, 1);
        issue(16'h0064, 8'hF9, 1, 1, e);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk("stall_valid", Out_Valid, 1);
            chk("stall_in_ready", In_Ready, 0);
            chk("stall_quotient", Quotient, e.q);
            chk("stall_remainder", Remainder, e.r);
        end
        @(posedge Clk); #1 Out_Ready = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        chk("post_hs_in_ready", In_Ready, 1);
        chk("post_hs_out_valid", Out_Valid, 0);

        // Reset in the middle of CALC
        e = model(16'h3F01, 8'h7F, 0, 0);
        issue(16'h3F01, 8'h7F, 0, 0, e);
        repeat (6) @(posedge Clk);
        #1 Reset = 1'b1;
        @(posedge Clk); #1 Reset = 1'b0;
        sb.delete();
        @(negedge Clk);
        chk("calc_rst_in_ready", In_Ready, 1);
        chk("calc_rst_out_valid", Out_Valid, 0);
        any_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge Clk);
            if (Out_Valid) any_valid = 1'b1;
        end
        chk("calc_rst_no_valid", any_valid, 0);
        run_dir(16'hFFF9, 8'h02, 1, 1, 8'hFD, 9'h1FF, 0, 0);

        // Reset while a result waits in DONE
        @(posedge Clk); #1 Out_Ready = 1'b0;
        e = model(16'hFF80, 8'h00, 1, 1);
        issue(16'hFF80, 8'h00, 1, 1, e);
        wait_valid();
        @(posedge Clk); #1 Reset = 1'b1;
        @(posedge Clk); #1 Reset = 1'b0;
        sb.delete();
        Out_Ready = 1'b1;
        @(negedge Clk);
        chk("done_rst_out_valid", Out_Valid, 0);
        chk("done_rst_quotient", Quotient, 0);
        chk("done_rst_remainder", Remainder, 0);
        chk("done_rst_divbyzero", DivByZero, 0);
        chk("done_rst_in_ready", In_Ready, 1);

        for (int i = 0; i < 40; i++) begin
            rd = 16'($urandom) >> $urandom_range(0, 10);
            rv = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            ra = 1'($urandom);
            rb = 1'($urandom);
            e  = model(rd, rv, ra, rb);
            issue(rd, rv, ra, rb, e);
            wait_done();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/scaled_divider.md
SCALED_DIVIDER -- requirements
Module: scaled_divider

Interface
REQ-001 Parameter N, default 8: divisor, quotient and operand width; dividend is 2N bits, remainder N+1 bits.
REQ-002 Clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset; sampled on rising edge of Clk.
REQ-004 In_Valid  input  1  request present.
REQ-005 In_Ready  output  1  block accepts a request this cycle.
REQ-006 Dividend  input  2N  dividend; two's complement when A_Signed=1, else unsigned.
REQ-007 Divisor  input  N  divisor; two's complement when B_Signed=1, else unsigned.
REQ-008 A_Signed  input  1  dividend signedness.
REQ-009 B_Signed  input  1  divisor signedness.
REQ-010 Out_Valid  output  1  result present.
REQ-011 Out_Ready  input  1  consumer takes the result.
REQ-012 Quotient  output  N  quotient; signed iff A_Signed|B_Signed.
REQ-013 Remainder  output  N+1  remainder, always two's complement.
REQ-014 Overflow  output  1  quotient saturated.
REQ-015 DivByZero  output  1  divisor was zero.

Function
REQ-016 States: IDLE, CALC, FIX, DONE; In_Ready=1 only in IDLE; Out_Valid=1 only in DONE.
REQ-017 IDLE: In_Valid&In_Ready at edge k latches operands and flags, converts them to magnitudes and records result sign, then goes to CALC.
REQ-018 CALC: restoring division, one quotient bit per cycle, MSB first, exactly 2N cycles, then FIX.
REQ-019 FIX: apply signs, detect overflow and apply saturation, register outputs, then go to DONE.
REQ-020 Latency is fixed: Out_Valid first high at cycle k+2N+2 (18 for N=8), including the divide-by-zero case.
REQ-021 DONE: outputs stay stable while Out_Ready=0; Out_Valid&Out_Ready at an edge returns to IDLE.
REQ-022 A new request is accepted no earlier than the cycle after the handshake that completes the previous result; no pipelining.
REQ-023 Quotient rounds toward zero; remainder takes the sign of the dividend; Dividend = Quotient*Divisor + Remainder whenever Overflow=0.
REQ-024 Quotient is signed iff either operand is signed; an unsigned operand is zero-extended by one bit before combining.
REQ-025 Overflow=1 when the true quotient is outside the quotient range.
REQ-026 On overflow, Quotient saturates: signed positive 2^(N-1)-1, signed negative -2^(N-1), unsigned 2^N-1.
REQ-027 Divisor==0: DivByZero=1 and Overflow=0.
REQ-028 Divisor==0: Quotient saturates per REQ-026 using the dividend sign.
REQ-029 Divisor==0: Remainder = low N+1 bits of Dividend.
REQ-030 Most negative signed dividend and signed divisor -1 is a normal overflow case; no undefined behaviour.

Reset
REQ-031 Reset forces state IDLE.
REQ-032 Reset forces Out_Valid=0, Quotient=0, Remainder=0, Overflow=0 and DivByZero=0; In_Ready=1 from the first cycle after reset.
REQ-033 Reset mid-CALC, mid-FIX or in DONE discards the operation with no Out_Valid pulse; Reset has priority over any handshake.

Structure
REQ-034 Package scaled_divider_pkg holds the state enum, default N, and the saturation-constant functions.
REQ-035 Sub-module scaled_divider_core holds the unsigned 2N-by-N iterative datapath (shift register, partial remainder, bit counter); sign handling stays in the top level.

Verification
REQ-036 Unsigned 0x3F01 / 0x7F (127*127) -> Quotient 0x7F, Remainder 0, flags 0, Out_Valid exactly 18 cycles after accept.
REQ-037 Signed 0xC080 (-16256) / signed 0x7F -> Quotient 0x80 (-128), Remainder 0; signed -7 / signed 2 -> Quotient 0xFD (-3), Remainder 0x1FF (-1).
REQ-038 Unsigned 0x7F00 / 0x01 -> Overflow=1, Quotient 0xFF; signed 0x8000 / signed 0xFF -> Overflow=1, Quotient 0x7F.
REQ-039 Signed 0xFF80 / 0x00 -> DivByZero=1, Quotient 0x80, Remainder 0x180, latency 18.
REQ-040 Out_Ready held low 5 cycles in DONE -> outputs stable and In_Ready=0 throughout; handshake -> In_Ready=1 next cycle.
REQ-041 Reset asserted at CALC cycle 7 -> IDLE and In_Ready=1 next cycle, no Out_Valid; next request computes correctly.
